// File: rtl/caminho_pkg.sv
// Shared types and defaults for the path output stage.
// Holds the FSM encoding, default LIFO depth and index-width helper.
package caminho_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURA,
    ENVIO
  } estado_t;

  localparam int MAX_CAMINHO_PADRAO = 64;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/caminho_reverso_saida_pilha.sv
// LIFO storage for path nodes: one write port, async read below ptr.
// The pointer wraps in IDX_W bits, so ptr==depth reads the top entry.
module pilha_caminho
  import caminho_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int MAX_CAMINHO = MAX_CAMINHO_PADRAO,
  parameter int IDX_W       = idx_w(MAX_CAMINHO)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      ptr_i,
  input  logic [ADDR_WIDTH-1:0] wdata_i,
  output logic [ADDR_WIDTH-1:0] rdata_o
);

  logic [ADDR_WIDTH-1:0] mem_q [MAX_CAMINHO];
  logic [IDX_W-1:0]      rd_idx;

  assign rd_idx  = ptr_i - IDX_W'(1);
  assign rdata_o = mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[ptr_i] <= wdata_i;
  end

endmodule

// File: rtl/caminho_reverso_saida.sv
// Captures path nodes destination-first and replays them source-first
// on a valid/ready stream, reporting path length and overflow.
module caminho_reverso_saida
  import caminho_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int MAX_CAMINHO = MAX_CAMINHO_PADRAO,
  parameter int CNT_WIDTH   = $clog2(MAX_CAMINHO + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_inicio,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_fim,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  ocupado,
  output logic [CNT_WIDTH-1:0]  tamanho,
  output logic                  overflow
);

  localparam int IDX_W = idx_w(MAX_CAMINHO);

  estado_t               estado_q;
  logic [CNT_WIDTH-1:0]  ptr_q;
  logic [CNT_WIDTH-1:0]  tamanho_q;
  logic                  overflow_q;
  logic                  cheio;
  logic                  push;
  logic [ADDR_WIDTH-1:0] topo;

  assign cheio = (ptr_q == CNT_WIDTH'(MAX_CAMINHO));
  assign push  = (estado_q == CAPTURA) && in_valid
               && !in_inicio && !cheio;

  pilha_caminho #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_CAMINHO(MAX_CAMINHO),
    .IDX_W      (IDX_W)
  ) u_pilha (
    .clk    (clk),
    .we_i   (push),
    .ptr_i  (ptr_q[IDX_W-1:0]),
    .wdata_i(in_addr),
    .rdata_o(topo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= IDLE;
      ptr_q      <= '0;
      tamanho_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (estado_q)
        IDLE: begin
          if (in_inicio) begin
            estado_q   <= CAPTURA;
            ptr_q      <= '0;
            tamanho_q  <= '0;
            overflow_q <= 1'b0;
          end
        end
        CAPTURA: begin
          if (in_inicio) begin
            ptr_q      <= '0;
            tamanho_q  <= '0;
            overflow_q <= 1'b0;
          end else begin
            if (push) begin
              ptr_q     <= ptr_q + CNT_WIDTH'(1);
              tamanho_q <= tamanho_q + CNT_WIDTH'(1);
            end else if (in_valid) begin
              overflow_q <= 1'b1;
            end
            // Same-cycle push counts before deciding emptiness.
            if (in_fim) begin
              if (ptr_q == '0 && !push) estado_q <= IDLE;
              else                      estado_q <= ENVIO;
            end
          end
        end
        ENVIO: begin
          if (in_inicio) begin
            estado_q   <= CAPTURA;
            ptr_q      <= '0;
            tamanho_q  <= '0;
            overflow_q <= 1'b0;
          end else if (out_ready) begin
            ptr_q <= ptr_q - CNT_WIDTH'(1);
            if (ptr_q == CNT_WIDTH'(1)) estado_q <= IDLE;
          end
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign out_valid = (estado_q == ENVIO);
  assign out_addr  = out_valid ? topo : '0;
  assign out_last  = out_valid && (ptr_q == CNT_WIDTH'(1));
  assign ocupado   = (estado_q != IDLE);
  assign tamanho   = tamanho_q;
  assign overflow  = overflow_q;

endmodule
